// File: rtl/ysyx_22040386_pkg.sv
// Shared definitions for the RV64M divide sequencer: funct3 codes, FSM
// state encodings, datapath width and small result-formatting helpers.
package ysyx_22040386_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  typedef logic [1:0] div_state_t;

  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t CALC = 2'd1;
  localparam div_state_t DONE = 2'd2;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/ysyx_22040386_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor when the shifted remainder is large enough.
module ysyx_22040386_div_step
  import ysyx_22040386_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  // rem_in < divisor always holds, so the subtraction fits back into XLEN bits
  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/ysyx_22040386_div_ctrl.sv
// Iterative DIV/DIVU/REM/REMU (+W) sequencer: valid/ready request side,
// restoring division over magnitudes, early special cases, backpressured result.
module ysyx_22040386_div_ctrl
  import ysyx_22040386_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [2:0]      i_funct3,
  input  logic            i_word_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  div_state_t      state;
  logic [5:0]      cnt;
  logic [XLEN-1:0] dvd_q, dvs_q, rem_q, quo_q, res_q;
  logic            word_q, is_rem_q, q_neg_q, r_neg_q;

  logic            is_signed, is_rem;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2;
  logic            s1, s2, div_zero, overflow;
  logic [XLEN-1:0] special_raw, special_res;

  logic [XLEN-1:0] step_rem, quo_next, final_raw, final_res;
  logic            step_q;

  assign o_div_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);

  // Decode and operand preparation for the request currently presented
  always_comb begin
    is_signed = (i_funct3 == DIV) || (i_funct3 == REM);
    is_rem    = !((i_funct3 == DIV) || (i_funct3 == DIVU));
    if (i_word_op) begin
      ext1 = is_signed ? sext_word(i_src1) : {{(XLEN-32){1'b0}}, i_src1[31:0]};
      ext2 = is_signed ? sext_word(i_src2) : {{(XLEN-32){1'b0}}, i_src2[31:0]};
    end else begin
      ext1 = i_src1;
      ext2 = i_src2;
    end
    s1   = is_signed & ext1[XLEN-1];
    s2   = is_signed & ext2[XLEN-1];
    mag1 = neg_if(s1, ext1);
    mag2 = neg_if(s2, ext2);

    div_zero = (ext2 == '0);
    overflow = is_signed && (ext2 == '1) &&
               (ext1 == (i_word_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

    if (div_zero) special_raw = is_rem ? ext1 : '1;
    else          special_raw = is_rem ? '0 : ext1;
    special_res = i_word_op ? sext_word(special_raw) : special_raw;
  end

  ysyx_22040386_div_step u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[cnt]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign correction of the last step's outputs, captured when entering DONE
  always_comb begin
    quo_next  = {quo_q[XLEN-2:0], step_q};
    final_raw = is_rem_q ? neg_if(r_neg_q, step_rem) : neg_if(q_neg_q, quo_next);
    final_res = word_q ? sext_word(final_raw) : final_raw;
  end

  // FSM, iteration datapath and output register; flush overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      res_q       <= '0;
      word_q      <= 1'b0;
      is_rem_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      o_out_valid <= 1'b0;
      o_result    <= '0;
    end else if (i_flush) begin
      state       <= IDLE;
      cnt         <= '0;
      o_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_div_valid) begin
            word_q   <= i_word_op;
            is_rem_q <= is_rem;
            q_neg_q  <= s1 ^ s2;
            r_neg_q  <= s1;
            dvd_q    <= mag1;
            dvs_q    <= mag2;
            rem_q    <= '0;
            quo_q    <= '0;
            if (div_zero || overflow) begin
              res_q <= special_res;
              state <= DONE;
            end else begin
              cnt   <= i_word_op ? 6'd31 : 6'd63;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= quo_next;
          if (cnt == 6'd0) begin
            res_q <= final_res;
            state <= DONE;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        DONE: begin
          if (!o_out_valid) begin
            o_result    <= res_q;
            o_out_valid <= 1'b1;
          end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_22040386_div_ctrl.md
# ysyx_22040386_div_ctrl

Iterative RV64M divide/remainder sequencer that sits next to the EX-stage ALU. EX hands it DIV/DIVU/REM/REMU (and W variants) operands through a valid/ready handshake and holds the pipeline on `o_busy`. The block runs a radix-2 restoring division, resolves RISC-V special cases early, and returns one 64-bit result per request. Results wait for consumer backpressure, and in-flight work can be flushed.

## Interface
- `XLEN`, 64: operand/result width; only 64 is supported.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `i_flush`  in  1: kill any in-flight or pending operation.
- `i_div_valid`  in  1: EX presents a divide op.
- `o_div_ready`  out  1: block can accept an op.
- `i_funct3`  in  3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are not issued.
- `i_word_op`  in  1: W-variant (32-bit operation, sign-extended result).
- `i_src1`  in  64: dividend.
- `i_src2`  in  64: divisor.
- `o_out_valid`  out  1: result is available.
- `i_out_ready`  in  1: consumer takes the result.
- `o_result`  out  64: quotient or remainder.
- `o_busy`  out  1: request accepted and result not yet consumed; EX stalls on it.

## Operation
- **Accept.** A request is accepted when `i_div_valid & o_div_ready & ~i_flush`. Opcode, word flag, operand signs and magnitudes are latched on that edge.
- **Ready.** `o_div_ready` = (state == IDLE).
- **States.**
  - IDLE → CALC on accept, for the normal case.
  - IDLE → DONE on accept, for special cases.
  - CALC → DONE when the iteration counter reaches 0.
  - DONE → IDLE on `o_out_valid & i_out_ready`.
  - Any state → IDLE on `i_flush`.
- **Width.**
  - N = 32 when `i_word_op`, else 64.
  - Word ops use `src[31:0]`, sign-extended for signed ops and zero-extended for unsigned ops.
- **Signed ops.** Operands are converted to magnitudes. The quotient is negated iff the operand signs differ. The remainder takes the dividend's sign. Correction is applied when entering DONE.
- **CALC.**
  - One restoring step per cycle: shift the partial remainder left by 1, bring in the next dividend bit, then subtract the divisor if remainder ≥ divisor and set the quotient bit.
  - The counter loads N−1 on accept and decrements each CALC cycle.
- **Special cases** (decided at accept; result registered directly):
  - Divisor == 0: quotient = all ones (word: −1 sign-extended); remainder = dividend (word: `sext(src1[31:0])`).
  - Signed overflow, i.e. dividend = most-negative value of width N and divisor = −1: quotient = dividend (word: `0xFFFFFFFF80000000`); remainder = 0.
- **Result selection.** `o_result` = quotient for DIV/DIVU, remainder for REM/REMU. Word results are `sext(res[31:0])`.
- **Busy.** `o_busy` = (state != IDLE).

## Timing
- **Reset values.** state IDLE, `o_out_valid` 0, `o_result` 0, `o_busy` 0, `o_div_ready` 1, counter 0.
- **Latency**, with accept on edge k:
  - Normal case: CALC occupies cycles k+1 … k+N. `o_out_valid` rises after edge k+N+1: 65 cycles (64-bit) or 33 cycles (word) after accept.
  - Special cases: `o_out_valid` rises after edge k+1.
- **Output hold.** `o_result` is stable while `o_out_valid` is high and `i_out_ready` is low. Backpressure has no time limit.
- **Throughput.** At least one IDLE cycle separates consecutive requests; no accept in the same cycle as result handoff.
- **Flush.**
  - Flush wins over a simultaneous accept: the op is dropped and ready stays high.
  - Flush in CALC or DONE: IDLE on the next edge, `o_out_valid` low, result discarded.
  - Flush simultaneous with a result handshake: the handshake completes (the consumer saw valid&ready) and the state goes to IDLE.
- **Reset mid-operation** forces all reset values immediately.
- **Stability.** Inputs other than the handshake signals are ignored outside the accept edge.

## Structure
- Shared package `ysyx_22040386_pkg` holds:
  - the funct3 constants `DIV`/`DIVU`/`REM`/`REMU`;
  - the state enum `IDLE`/`CALC`/`DONE`;
  - XLEN.
- One sub-module `ysyx_22040386_div_step`: combinational single restoring step (partial remainder, divisor → new remainder, quotient bit).
- The controller owns the FSM, counter, sign bookkeeping, special-case logic and output register.

## Test plan
- **DIVU basic.** DIVU 100 / 7, 64-bit → `o_result` 14, valid exactly 65 cycles after accept. REMU with the same operands → 2.
- **Signed sign rules.** DIV −7 / 2 → −3 (`0xFFFFFFFFFFFFFFFD`). REM −7 / 2 → −1. REM 7 / −2 → 1.
- **Divide by zero.** DIV 5 / 0 → `0xFFFFFFFFFFFFFFFF`, REMU 5 / 0 → 5, each valid 1 cycle after accept.
- **Signed overflow.**
  - DIV `0x8000000000000000` / −1 → `0x8000000000000000`.
  - DIVW (`i_word_op`) `0x80000000` / −1 → `0xFFFFFFFF80000000`, valid after 1 cycle.
  - REMW with the same operands → 0.
- **Word op latency.** DIVUW `0xFFFFFFFF` / 1 → `0xFFFFFFFFFFFFFFFF` (sign-extended) after 33 cycles.
- **Flush and backpressure.**
  - Flush at CALC cycle 10 → next cycle IDLE, ready 1, no valid.
  - With `i_out_ready` held low for 20 cycles → result stable and `o_busy` high throughout.
  - Flush with simultaneous `i_div_valid` → request not accepted.
